// File: rtl/ws2812_serializer_if.sv
`default_nettype none
// ============================================================
// ws2812_serializer_if : pixel word valid/ready stream
// Rev 1.0
// ============================================================
interface ws2812_serializer_if #(
  parameter int BITS_PER_PIXEL = 24
);
  logic [BITS_PER_PIXEL-1:0] pixel_data;
  logic                      pixel_valid;
  logic                      pixel_ready;

  modport master (output pixel_data, output pixel_valid, input  pixel_ready);
  modport slave  (input  pixel_data, input  pixel_valid, output pixel_ready);
endinterface
`default_nettype wire

// File: rtl/ws2812_serializer.sv
`default_nettype none
// ============================================================
// ws2812_serializer : WS2812-style single-wire LED pixel serializer
// Rev 1.0
// ============================================================
module ws2812_serializer #(
  parameter int BITS_PER_PIXEL = 24,
  parameter int NUM_PIXELS     = 64,
  parameter int LSB_FIRST      = 0,
  parameter int T0H_CYC        = 20,
  parameter int T1H_CYC        = 40,
  parameter int TBIT_CYC       = 62,
  parameter int TRESET_CYC     = 2500
) (
  input  logic                clk,
  input  logic                rst,
  ws2812_serializer_if.slave  s_pix,
  output logic                o_dout,
  output logic                o_busy,
  output logic                o_frame_done,
  output logic                o_underrun
);

  localparam int c_CW = $clog2(((TBIT_CYC > TRESET_CYC) ? TBIT_CYC : TRESET_CYC) + 1);
  localparam int c_BW = (BITS_PER_PIXEL > 1) ? $clog2(BITS_PER_PIXEL) : 1;
  localparam int c_PW = $clog2(NUM_PIXELS + 1);

  localparam logic [c_CW-1:0] c_CNT_ONE  = c_CW'(1);
  localparam logic [c_CW-1:0] c_T0H_M1   = c_CW'(T0H_CYC - 1);
  localparam logic [c_CW-1:0] c_T1H_M1   = c_CW'(T1H_CYC - 1);
  localparam logic [c_CW-1:0] c_TBIT_M1  = c_CW'(TBIT_CYC - 1);
  localparam logic [c_CW-1:0] c_TBIT_M2  = c_CW'(TBIT_CYC - 2);
  localparam logic [c_CW-1:0] c_TRST_M1  = c_CW'(TRESET_CYC - 1);
  localparam logic [c_BW-1:0] c_BIT_LAST = c_BW'(BITS_PER_PIXEL - 1);
  localparam logic [c_BW-1:0] c_BIT_ONE  = c_BW'(1);
  localparam logic [c_PW-1:0] c_PIX_ONE  = c_PW'(1);
  localparam logic [c_PW-1:0] c_NUM_PIX  = c_PW'(NUM_PIXELS);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_HIGH  = 3'd1,
    S_LOW   = 3'd2,
    S_WAIT  = 3'd3,
    S_LATCH = 3'd4
  } state_t;

  state_t                    r_state;
  logic [BITS_PER_PIXEL-1:0] r_shift;
  logic [c_BW-1:0]           r_bit_cnt;
  logic [c_PW-1:0]           r_pix_cnt;
  logic [c_CW-1:0]           r_cyc;
  logic                      r_dout;
  logic                      r_ready;
  logic                      r_busy;
  logic                      r_frame_done;
  logic                      r_underrun;

  logic                      w_xfer;
  logic                      w_cur_bit;
  logic [c_CW-1:0]           w_hi_last;
  logic                      w_last_bit;
  logic                      w_more_pix;
  logic                      w_chain_rdy;
  logic [BITS_PER_PIXEL-1:0] w_shift_nxt;

  assign w_xfer      = s_pix.pixel_valid & r_ready;
  assign w_cur_bit   = (LSB_FIRST != 0) ? r_shift[0] : r_shift[BITS_PER_PIXEL-1];
  assign w_hi_last   = w_cur_bit ? c_T1H_M1 : c_T0H_M1;
  assign w_last_bit  = (r_bit_cnt == c_BIT_LAST);
  assign w_more_pix  = (r_pix_cnt < c_NUM_PIX);
  assign w_shift_nxt = (LSB_FIRST != 0) ? (r_shift >> 1) : (r_shift << 1);
  // Ready is raised one cycle early so it is visible in the final LOW cycle.
  assign w_chain_rdy = (r_cyc == c_TBIT_M2) && w_last_bit && w_more_pix;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_LATCH;
      r_shift      <= '0;
      r_bit_cnt    <= '0;
      r_pix_cnt    <= '0;
      r_cyc        <= '0;
      r_dout       <= 1'b0;
      r_ready      <= 1'b0;
      r_busy       <= 1'b1;
      r_frame_done <= 1'b0;
      r_underrun   <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      r_underrun   <= 1'b0;
      case (r_state)
        S_IDLE, S_WAIT: begin
          if (w_xfer) begin
            r_shift   <= s_pix.pixel_data;
            r_bit_cnt <= '0;
            r_pix_cnt <= r_pix_cnt + c_PIX_ONE;
            r_cyc     <= '0;
            r_dout    <= 1'b1;
            r_ready   <= 1'b0;
            r_busy    <= 1'b1;
            r_state   <= S_HIGH;
          end
        end
        S_HIGH: begin
          r_cyc   <= r_cyc + c_CNT_ONE;
          r_ready <= w_chain_rdy;
          if (r_cyc == w_hi_last) begin
            r_dout  <= 1'b0;
            r_state <= S_LOW;
          end
        end
        S_LOW: begin
          if (r_cyc == c_TBIT_M1) begin
            r_cyc   <= '0;
            r_ready <= 1'b0;
            if (!w_last_bit) begin
              r_bit_cnt <= r_bit_cnt + c_BIT_ONE;
              r_shift   <= w_shift_nxt;
              r_dout    <= 1'b1;
              r_state   <= S_HIGH;
            end else begin
              r_bit_cnt <= '0;
              if (w_more_pix) begin
                if (w_xfer) begin
                  r_shift   <= s_pix.pixel_data;
                  r_pix_cnt <= r_pix_cnt + c_PIX_ONE;
                  r_dout    <= 1'b1;
                  r_state   <= S_HIGH;
                end else begin
                  r_ready    <= 1'b1;
                  r_underrun <= 1'b1;
                  r_state    <= S_WAIT;
                end
              end else begin
                r_pix_cnt <= '0;
                r_state   <= S_LATCH;
              end
            end
          end else begin
            r_cyc   <= r_cyc + c_CNT_ONE;
            r_ready <= w_chain_rdy;
          end
        end
        S_LATCH: begin
          if (r_cyc == c_TRST_M1) begin
            r_cyc        <= '0;
            r_ready      <= 1'b1;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b1;
            r_state      <= S_IDLE;
          end else begin
            r_cyc <= r_cyc + c_CNT_ONE;
          end
        end
        default: begin
          r_cyc   <= '0;
          r_dout  <= 1'b0;
          r_ready <= 1'b0;
          r_busy  <= 1'b1;
          r_state <= S_LATCH;
        end
      endcase
    end
  end

  assign s_pix.pixel_ready = r_ready;
  assign o_dout            = r_dout;
  assign o_busy            = r_busy;
  assign o_frame_done      = r_frame_done;
  assign o_underrun        = r_underrun;

endmodule
`default_nettype wire

// File: tb/tb_ws2812_serializer.sv
`default_nettype none
// ============================================================
// tb_ws2812_serializer : waveform-model bench for ws2812_serializer
// Rev 1.0
// ============================================================
module tb_ws2812_serializer;

  localparam int B     = 8;
  localparam int NPIX  = 2;
  localparam int T0H   = 2;
  localparam int T1H   = 4;
  localparam int TBIT  = 6;
  localparam int TRST  = 10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ws2812_serializer_if #(.BITS_PER_PIXEL(B)) ifa ();
  ws2812_serializer_if #(.BITS_PER_PIXEL(B)) ifb ();

  logic a_dout, a_busy, a_fd, a_ur;
  logic b_dout, b_busy, b_fd, b_ur;

  ws2812_serializer #(
    .BITS_PER_PIXEL(B), .NUM_PIXELS(NPIX), .LSB_FIRST(0),
    .T0H_CYC(T0H), .T1H_CYC(T1H), .TBIT_CYC(TBIT), .TRESET_CYC(TRST)
  ) u_msb (
    .clk(clk), .rst(rst), .s_pix(ifa),
    .o_dout(a_dout), .o_busy(a_busy), .o_frame_done(a_fd), .o_underrun(a_ur)
  );

  ws2812_serializer #(
    .BITS_PER_PIXEL(B), .NUM_PIXELS(NPIX), .LSB_FIRST(1),
    .T0H_CYC(T0H), .T1H_CYC(T1H), .TBIT_CYC(TBIT), .TRESET_CYC(TRST)
  ) u_lsb (
    .clk(clk), .rst(rst), .s_pix(ifb),
    .o_dout(b_dout), .o_busy(b_busy), .o_frame_done(b_fd), .o_underrun(b_ur)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic drive(input int sel, input logic v, input logic [7:0] d);
    if (sel == 0) begin
      ifa.pixel_valid = v;
      ifa.pixel_data  = d;
    end else begin
      ifb.pixel_valid = v;
      ifb.pixel_data  = d;
    end
  endtask

  // {dout, ready, underrun, frame_done, busy}
  function automatic logic [4:0] sample(input int sel);
    if (sel == 0) return {a_dout, ifa.pixel_ready, a_ur, a_fd, a_busy};
    return {b_dout, ifb.pixel_ready, b_ur, b_fd, b_busy};
  endfunction

  task automatic test_reset();
    int lows;
    bit done;
    rst = 1'b1;
    drive(0, 1'b0, 8'h00);
    drive(1, 1'b0, 8'h00);
    repeat (3) @(posedge clk);
    #1;
    for (int s = 0; s < 2; s++) begin
      n_cmp++;
      if (sample(s) !== 5'b00001) begin
        n_err++;
        $display("FAIL reset_state dut%0d: got %b want 00001", s, sample(s));
      end
    end
    rst = 1'b0;
    lows = 0;
    done = 1'b0;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (ifa.pixel_ready) done = 1'b1;
      else lows++;
    end
    n_cmp++;
    if (lows !== TRST) begin
      n_err++;
      $display("FAIL reset_latch_len: got %0d want %0d", lows, TRST);
    end
    n_cmp++;
    if (sample(0) !== 5'b01010) begin
      n_err++;
      $display("FAIL reset_idle_entry: got %b want 01010", sample(0));
    end
  endtask

  // Two-pixel frame; pixel 1 is offered 'gap' cycles after the chaining slot.
  task automatic test_frame(input int sel, input logic [7:0] w0, input logic [7:0] w1,
                            input int gap, input string tag, output logic [255:0] d_out);
    logic [255:0] act [5];
    logic [255:0] exp [5];
    logic [7:0]   w   [2];
    string        nm  [5];
    int           idx, len, first, th;
    logic         bv;
    logic [4:0]   s;
    nm = '{"dout", "ready", "underrun", "frame_done", "busy"};
    w[0] = w0;
    w[1] = w1;
    for (int k = 0; k < 5; k++) begin
      act[k] = '0;
      exp[k] = '0;
    end
    idx = 0;
    for (int p = 0; p < 2; p++) begin
      if (p == 1) begin
        if (gap > 0) exp[2][idx] = 1'b1;
        for (int g = 0; g < gap; g++) begin
          exp[1][idx] = 1'b1;
          idx++;
        end
      end
      for (int b = 0; b < B; b++) begin
        bv = (sel == 1) ? w[p][b] : w[p][B-1-b];
        th = bv ? T1H : T0H;
        for (int c = 0; c < TBIT; c++) begin
          exp[0][idx] = (c < th);
          if (p == 0 && b == B-1 && c == TBIT-1) exp[1][idx] = 1'b1;
          idx++;
        end
      end
    end
    len = idx + TRST + 2;
    for (int i = 0; i < idx + TRST; i++) exp[4][i] = 1'b1;
    exp[3][idx + TRST] = 1'b1;
    for (int i = idx + TRST; i < len; i++) exp[1][i] = 1'b1;

    @(posedge clk);
    #1 drive(sel, 1'b1, w0);
    @(posedge clk);
    #1 drive(sel, (gap == 0), w1);
    fork
      begin
        for (int k = 1; k <= 48 + gap; k++) begin
          @(posedge clk);
          #1;
          if (k == 47 + gap) drive(sel, 1'b1, w1);
          if (k == 48 + gap) drive(sel, 1'b0, 8'h00);
        end
      end
      begin
        for (int i = 0; i < len; i++) begin
          @(negedge clk);
          s = sample(sel);
          act[0][i] = s[4];
          act[1][i] = s[3];
          act[2][i] = s[2];
          act[3][i] = s[1];
          act[4][i] = s[0];
        end
      end
    join
    for (int k = 0; k < 5; k++) begin
      n_cmp++;
      if (act[k] !== exp[k]) begin
        n_err++;
        first = 0;
        for (int j = 255; j >= 0; j--) if (act[k][j] !== exp[k][j]) first = j;
        $display("FAIL %s %s at cycle %0d: got %b want %b", tag, nm[k], first,
                 act[k][first], exp[k][first]);
      end
    end
    d_out = act[0];
  endtask

  task automatic test_mux_a5();
    logic [255:0] d;
    int hi;
    int want [8];
    want = '{4, 2, 4, 2, 2, 4, 2, 4};
    test_frame(0, 8'hA5, 8'($urandom), 0, "a5", d);
    for (int b = 0; b < 8; b++) begin
      hi = 0;
      for (int c = 0; c < TBIT; c++) hi += int'(d[b*TBIT + c]);
      n_cmp++;
      if (hi !== want[b]) begin
        n_err++;
        $display("FAIL a5_high_time bit%0d: got %0d want %0d", b, hi, want[b]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [255:0] d;
    int ones;
    test_frame(0, 8'hFF, 8'h00, 0, "b2b", d);
    ones = 0;
    for (int i = 0; i < 2*B*TBIT; i++) ones += int'(d[i]);
    n_cmp++;
    if (ones !== 8*T1H + 8*T0H) begin
      n_err++;
      $display("FAIL b2b_high_cycles: got %0d want %0d", ones, 8*T1H + 8*T0H);
    end
  endtask

  task automatic test_underrun();
    logic [255:0] d;
    test_frame(0, 8'h80, 8'h01, 7, "underrun", d);
    n_cmp++;
    if (d[48 +: 7] !== 7'b0) begin
      n_err++;
      $display("FAIL underrun_gap_low: got %b want 0000000", d[48 +: 7]);
    end
  endtask

  task automatic test_lsb_first();
    logic [255:0] d;
    int hi;
    test_frame(1, 8'h01, 8'($urandom), 0, "lsb", d);
    for (int b = 0; b < 8; b++) begin
      hi = 0;
      for (int c = 0; c < TBIT; c++) hi += int'(d[b*TBIT + c]);
      n_cmp++;
      if (hi !== ((b == 0) ? T1H : T0H)) begin
        n_err++;
        $display("FAIL lsb_high_time bit%0d: got %0d want %0d", b, hi, (b == 0) ? T1H : T0H);
      end
    end
  endtask

  task automatic test_random();
    logic [255:0] d;
    for (int r = 0; r < 8; r++) begin
      test_frame(r % 2, 8'($urandom), 8'($urandom), int'($urandom_range(0, 8)), "random", d);
    end
  endtask

  task automatic test_reset_midbit();
    int lows;
    int highs;
    bit done;
    @(posedge clk);
    #1 drive(0, 1'b1, 8'($urandom));
    @(posedge clk);
    #1 drive(0, 1'b0, 8'h00);
    repeat (19) @(posedge clk);
    #2;
    n_cmp++;
    if (a_dout !== 1'b1) begin
      n_err++;
      $display("FAIL midbit_pre_high: got %b want 1", a_dout);
    end
    rst = 1'b1;
    #1;
    n_cmp++;
    if (sample(0) !== 5'b00001) begin
      n_err++;
      $display("FAIL midbit_async_reset: got %b want 00001", sample(0));
    end
    @(posedge clk);
    #1 rst = 1'b0;
    lows = 0;
    highs = 0;
    done = 1'b0;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      highs += int'(a_dout);
      if (ifa.pixel_ready) done = 1'b1;
      else lows++;
    end
    n_cmp++;
    if (lows !== TRST || highs !== 0) begin
      n_err++;
      $display("FAIL midbit_latch_gap: got %0d low-ready cycles, %0d dout-high; want %0d, 0",
               lows, highs, TRST);
    end
    n_cmp++;
    if (a_busy !== 1'b0) begin
      n_err++;
      $display("FAIL midbit_idle: got busy=%b want 0", a_busy);
    end
  endtask

  initial begin
    drive(0, 1'b0, 8'h00);
    drive(1, 1'b0, 8'h00);
    test_reset();
    test_mux_a5();
    test_back_to_back();
    test_underrun();
    test_lsb_first();
    test_random();
    test_reset_midbit();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
